// File: rtl/fir_engine.sv
// fir_engine: 4-tap unsigned FIR engine with Q0.16 coefficients.
// Samples arrive as rising edges of data_ready. Each one is shifted into a
// 4-deep history and run through a one-product-per-cycle MAC; the result is
// saturated to 16 bits. One sample can wait in a pending slot while the
// engine is busy. A sample arriving when that slot is full is dropped and
// raises err.
module fir_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ready,
    input  logic [15:0] sample_data,
    input  logic        new_coefficient_set,
    input  logic [15:0] fir_coefficient,
    output logic [1:0]  coefficient_num,
    output logic        clear_coeff,
    output logic        modwait,
    output logic [15:0] fir_out,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        ACK   = 4'd2,
        SHIFT = 4'd3,
        MAC0  = 4'd4,
        MAC1  = 4'd5,
        MAC2  = 4'd6,
        MAC3  = 4'd7,
        DONE  = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] coeff_q [4];
    logic [15:0] coeff_d [4];
    logic [15:0] x_q [4];
    logic [15:0] x_d [4];
    logic [33:0] acc_q, acc_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic [15:0] cur_q, cur_d;
    logic        dr_q, dr_d;
    logic [15:0] fir_out_q, fir_out_d;
    logic        err_q, err_d;
    logic        modwait_q, modwait_d;
    logic        clear_q, clear_d;
    logic [1:0]  cnum_q, cnum_d;

    logic        sample_edge;
    logic        consume;
    logic [1:0]  mac_idx;
    logic [31:0] prod;

    assign sample_edge = data_ready & ~dr_q;

    // Product for the tap selected by the current MAC state.
    always_comb begin
        mac_idx = 2'd0;
        case (state_q)
            MAC1:    mac_idx = 2'd1;
            MAC2:    mac_idx = 2'd2;
            MAC3:    mac_idx = 2'd3;
            default: mac_idx = 2'd0;
        endcase
        prod = {16'd0, x_q[mac_idx]} * {16'd0, coeff_q[mac_idx]};
    end

    // Next-state, datapath and pending-slot logic. Registered outputs are
    // decoded from the next state so that they line up with the state itself.
    always_comb begin
        state_d    = state_q;
        coeff_d    = coeff_q;
        x_d        = x_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cur_d      = cur_q;
        dr_d       = data_ready;
        fir_out_d  = fir_out_q;
        err_d      = err_q;
        consume    = 1'b0;

        case (state_q)
            IDLE: begin
                // A coefficient reload wins over a waiting sample.
                if (new_coefficient_set) begin
                    state_d = LOAD;
                end else if (pend_q || sample_edge) begin
                    state_d = SHIFT;
                    consume = 1'b1;
                    cur_d   = pend_q ? pend_val_q : sample_data;
                end
            end
            LOAD: begin
                coeff_d[cnum_q] = fir_coefficient;
                if (cnum_q == 2'd3) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            SHIFT: begin
                x_d[3]  = x_q[2];
                x_d[2]  = x_q[1];
                x_d[1]  = x_q[0];
                x_d[0]  = cur_q;
                acc_d   = '0;
                state_d = MAC0;
            end
            MAC0, MAC1, MAC2: begin
                acc_d   = acc_q + {2'b00, prod};
                state_d = state_t'(state_q + 4'd1);
            end
            MAC3: begin
                acc_d   = acc_q + {2'b00, prod};
                state_d = DONE;
            end
            DONE: begin
                if (acc_q[33:32] == 2'b00) begin
                    fir_out_d = acc_q[31:16];
                    err_d     = 1'b0;
                end else begin
                    fir_out_d = 16'hFFFF;
                    err_d     = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pending slot: it refills if a new edge arrives in the same cycle
        // that the slot is drained. Overflow drops the new sample and keeps
        // the old one. The overrun err takes precedence over a DONE update.
        if (consume && pend_q) begin
            pend_d = sample_edge;
            if (sample_edge) begin
                pend_val_d = sample_data;
            end
        end else if (sample_edge && !consume) begin
            if (!pend_q) begin
                pend_d     = 1'b1;
                pend_val_d = sample_data;
            end else begin
                err_d = 1'b1;
            end
        end

        modwait_d = (state_d != IDLE);
        clear_d   = (state_d == ACK);
        if (state_d == LOAD) begin
            cnum_d = (state_q == LOAD) ? cnum_q + 2'd1 : 2'd0;
        end else begin
            cnum_d = 2'd0;
        end
    end

    // State and datapath registers; reset abandons any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < 4; i++) begin
                coeff_q[i] <= '0;
                x_q[i]     <= '0;
            end
            acc_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            cur_q      <= '0;
            dr_q       <= 1'b0;
            fir_out_q  <= '0;
            err_q      <= 1'b0;
            modwait_q  <= 1'b0;
            clear_q    <= 1'b0;
            cnum_q     <= '0;
        end else begin
            state_q    <= state_d;
            coeff_q    <= coeff_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            cur_q      <= cur_d;
            dr_q       <= dr_d;
            fir_out_q  <= fir_out_d;
            err_q      <= err_d;
            modwait_q  <= modwait_d;
            clear_q    <= clear_d;
            cnum_q     <= cnum_d;
        end
    end

    assign coefficient_num = cnum_q;
    assign clear_coeff     = clear_q;
    assign modwait         = modwait_q;
    assign fir_out         = fir_out_q;
    assign err             = err_q;

endmodule

// File: tb/tb_fir_engine.sv
// Testbench for fir_engine: a reference model pushes expected results to a
// scoreboard queue as samples are driven, and a monitor pops and compares
// them when the engine finishes each computation.
module tb_fir_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ready = 1'b0;
    logic [15:0] sample_data = '0;
    logic        new_coefficient_set = 1'b0;
    logic [15:0] fir_coefficient;
    logic [1:0]  coefficient_num;
    logic        clear_coeff;
    logic        modwait;
    logic [15:0] fir_out;
    logic        err;

    logic [15:0] tb_coef [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] f;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [15:0] mx [4];
    logic [15:0] mc [4];
    logic        prev_mw  = 1'b0;
    logic        prev_clr = 1'b0;

    fir_engine dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_ready          (data_ready),
        .sample_data         (sample_data),
        .new_coefficient_set (new_coefficient_set),
        .fir_coefficient     (fir_coefficient),
        .coefficient_num     (coefficient_num),
        .clear_coeff         (clear_coeff),
        .modwait             (modwait),
        .fir_out             (fir_out),
        .err                 (err)
    );

    // Coefficient bus: returns the coefficient that the engine is fetching, in the same cycle.
    assign fir_coefficient = tb_coef[coefficient_num];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: shift in a sample, form the 34-bit sum, and enqueue the expected result.
    function automatic void model_push(input logic [15:0] s, input int due);
        logic [33:0] acc;
        exp_t        e;
        mx[3] = mx[2];
        mx[2] = mx[1];
        mx[1] = mx[0];
        mx[0] = s;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + ({18'd0, mx[i]} * {18'd0, mc[i]});
        end
        if (acc[33:32] == 2'b00) begin
            e.f = acc[31:16];
            e.e = 1'b0;
        end else begin
            e.f = 16'hFFFF;
            e.e = 1'b1;
        end
        e.due = due;
        sb.push_back(e);
    endfunction

    // Monitor: a result is ready on the first idle cycle after a busy period that did not end in ACK.
    always @(negedge clk) begin
        if (rst) begin
            prev_mw  = 1'b0;
            prev_clr = 1'b0;
        end else begin
            if (prev_mw && !modwait && !prev_clr) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result fir_out=%h err=%b (no result expected)", fir_out, err);
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (fir_out !== mon_e.f || err !== mon_e.e) begin
                        failures++;
                        $display("FAIL result fir_out=%h err=%b expected fir_out=%h err=%b",
                                 fir_out, err, mon_e.f, mon_e.e);
                    end else begin
                        $display("result fir_out=%h err=%b cycle=%0d", fir_out, err, cyc);
                    end
                    if (mon_e.due >= 0) begin
                        checks++;
                        if (cyc !== mon_e.due) begin
                            failures++;
                            $display("FAIL latency cycle=%0d expected=%0d", cyc, mon_e.due);
                        end
                    end
                end
            end
            prev_mw  = modwait;
            prev_clr = clear_coeff;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            mx[i] = '0;
            mc[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_ready = 1'b0;
        new_coefficient_set = 1'b0;
        model_clear();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic send_sample(input logic [15:0] v, input int hi, input bit expect_now);
        data_ready  = 1'b1;
        sample_data = v;
        model_push(v, expect_now ? cyc + 7 : -1);
        $display("sample %0d high=%0d cycle=%0d", v, hi, cyc);
        repeat (hi) tick();
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (fir_out !== 16'h0 || err !== 1'b0 || modwait !== 1'b0 ||
            clear_coeff !== 1'b0 || coefficient_num !== 2'd0) begin
            failures++;
            $display("FAIL reset_state fir_out=%h err=%b modwait=%b clear=%b num=%0d expected all zero",
                     fir_out, err, modwait, clear_coeff, coefficient_num);
        end else begin
            $display("reset outputs zero");
        end
        model_clear();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (modwait !== 1'b0 || fir_out !== 16'h0) begin
            failures++;
            $display("FAIL post_reset modwait=%b fir_out=%h expected 0 0", modwait, fir_out);
        end
    endtask

    task automatic test_coeff_load(input logic [15:0] c);
        for (int i = 0; i < 4; i++) tb_coef[i] = c;
        new_coefficient_set = 1'b1;
        tick();
        new_coefficient_set = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (coefficient_num !== 2'(k) || modwait !== 1'b1 || clear_coeff !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d num=%0d modwait=%b clear=%b expected num=%0d modwait=1 clear=0",
                         k, coefficient_num, modwait, clear_coeff, k);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (clear_coeff !== 1'b1 || modwait !== 1'b1 || coefficient_num !== 2'd0) begin
            failures++;
            $display("FAIL load_ack clear=%b modwait=%b num=%0d expected clear=1 modwait=1 num=0",
                     clear_coeff, modwait, coefficient_num);
        end
        tick();
        @(negedge clk);
        checks++;
        if (clear_coeff !== 1'b0 || modwait !== 1'b0) begin
            failures++;
            $display("FAIL load_end clear=%b modwait=%b expected 0 0", clear_coeff, modwait);
        end
        for (int i = 0; i < 4; i++) mc[i] = c;
        $display("coefficients loaded %h", c);
        tick();
    endtask

    task automatic test_filter_half();
        logic [15:0] vals [4];
        vals = '{16'd100, 16'd200, 16'd300, 16'd400};
        for (int i = 0; i < 4; i++) begin
            send_sample(vals[i], 2, 1'b1);
            repeat (10) tick();
        end
        wait_drain();
    endtask

    task automatic test_saturation();
        do_reset();
        test_coeff_load(16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            send_sample(16'hFFFF, 2, 1'b1);
            repeat (10) tick();
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        test_coeff_load(16'h8000);
        send_sample(16'd1000, 1, 1'b1);
        tick();
        send_sample(16'd2000, 1, 1'b0);
        tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL overrun_pre err=%b expected 0", err);
        end
        data_ready  = 1'b1;
        sample_data = 16'd3000;
        $display("sample 3000 dropped cycle=%0d", cyc);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL overrun_err err=%b expected 1", err);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_mac();
        send_sample(16'd1000, 2, 1'b1);
        wait_drain();
        data_ready  = 1'b1;
        sample_data = 16'd600;
        tick();
        data_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (fir_out !== 16'h0 || err !== 1'b0 || modwait !== 1'b0 ||
            clear_coeff !== 1'b0 || coefficient_num !== 2'd0) begin
            failures++;
            $display("FAIL mid_mac_reset fir_out=%h err=%b modwait=%b clear=%b num=%0d expected all zero",
                     fir_out, err, modwait, clear_coeff, coefficient_num);
        end else begin
            $display("reset during MAC2 outputs zero");
        end
        model_clear();
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        test_coeff_load(16'h4000);
        send_sample(16'd800, 2, 1'b1);
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tb_coef[i] = '0;
        test_reset();
        test_coeff_load(16'h8000);
        test_filter_half();
        test_saturation();
        test_back_to_back();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_engine.md
FIR_ENGINE -- requirements
Module: fir_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port data_ready, input, 1 bit: new-sample indication from the bus subordinate; may stay high 2 cycles per sample.
REQ-004 SHALL have port sample_data, input, 16 bits: unsigned sample, valid while data_ready is high.
REQ-005 SHALL have port new_coefficient_set, input, 1 bit: request to reload all 4 coefficients.
REQ-006 SHALL have port fir_coefficient, input, 16 bits: unsigned Q0.16 coefficient selected by coefficient_num, same-cycle valid.
REQ-007 SHALL have port coefficient_num, output, 2 bits: index of coefficient being fetched.
REQ-008 SHALL have port clear_coeff, output, 1 bit: one-cycle pulse acknowledging coefficient reload.
REQ-009 SHALL have port modwait, output, 1 bit: engine busy.
REQ-010 SHALL have port fir_out, output, 16 bits: last filter result.
REQ-011 SHALL have port err, output, 1 bit: overflow or sample-overrun flag.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ACK, SHIFT, MAC0, MAC1, MAC2, MAC3, DONE; modwait SHALL be 1 in every state except IDLE (registered, decoded from state).
REQ-013 SHALL detect a sample as a rising edge of data_ready (data_ready=1, previous-cycle data_ready=0), capturing sample_data in that cycle.
REQ-014 In IDLE, new_coefficient_set=1 SHALL go to LOAD; else a pending or just-detected sample SHALL go to SHIFT; coefficient reload has priority over a sample.
REQ-015 LOAD SHALL last 4 cycles with coefficient_num = 0,1,2,3 and capture fir_coefficient into coeff[coefficient_num] each cycle, then go to ACK.
REQ-016 ACK SHALL last 1 cycle with clear_coeff=1, then return to IDLE; clear_coeff SHALL be 0 in all other states.
REQ-017 coefficient_num SHALL be 0 outside LOAD.
REQ-018 SHIFT SHALL shift history x3<=x2, x2<=x1, x1<=x0, x0<=captured sample, and clear a 34-bit unsigned accumulator.
REQ-019 MACi (i=0..3) SHALL add the 32-bit unsigned product xi*coeff[i] to the accumulator, one product per cycle.
REQ-020 DONE SHALL register fir_out = acc[31:16] and err=0 when acc[33:32]==0; otherwise fir_out=16'hFFFF (saturation) and err=1; then return to IDLE.
REQ-021 Latency: edge detected in cycle N -> SHIFT N+1, MAC0-MAC3 N+2..N+5, DONE N+6; fir_out valid and modwait=0 from N+7.
REQ-022 A sample edge detected while not in IDLE SHALL be held in a one-deep pending register (value + flag) and processed on the next IDLE.
REQ-023 A sample edge arriving while the pending flag is already set SHALL be dropped and SHALL set err=1 immediately; the pending sample is retained.
REQ-024 err SHALL otherwise hold its value until the next DONE.
REQ-025 fir_out SHALL change only in DONE.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, coeff[0..3]=0, x0..x3=0, accumulator=0, pending flag=0, previous data_ready=0, fir_out=0, err=0, modwait=0, clear_coeff=0, coefficient_num=0.
REQ-027 Reset asserted mid-LOAD or mid-MAC SHALL abandon the operation without pulsing clear_coeff or updating fir_out.

Verification
REQ-028 new_coefficient_set=1 with fir_coefficient=0x8000 for every index -> coefficient_num 0,1,2,3 over 4 cycles, clear_coeff=1 in the 5th cycle, modwait=1 for all 5 cycles.
REQ-029 Coefficients all 0x8000; samples 100,200,300,400 each as a 2-cycle data_ready pulse -> fir_out 50, 150, 300, 500 (0x01F4) in turn, err=0, each 7 cycles after the rising edge.
REQ-030 Coefficients all 0xFFFF; four samples of 0xFFFF -> 4th result acc=0x3_FFF8_0004, fir_out=0xFFFF, err=1.
REQ-031 Three sample edges 2 cycles apart -> 2nd is queued and processed after the 1st; 3rd is dropped with err=1 the cycle after its edge.
REQ-032 data_ready held high 2 cycles -> exactly one computation.
REQ-033 rst pulsed during MAC2 -> all outputs 0, state IDLE, next sample computes against zero history.
